// File: rtl/key_debouncer.sv
// Pushbutton conditioner: a two-flop synchroniser, then a counter-qualified press/release FSM.
// Produces a clean level, one-cycle press/release strobes and a wrapping press counter.
module key_debouncer #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_WIDTH       = 19,
   parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
   input  logic       clock_50,
   input  logic       reset_n,
   input  logic       key_raw,
   output logic       key_clock,
   output logic       press_pulse,
   output logic       release_pulse,
   output logic [7:0] press_count,
   output logic [1:0] fsm_state
);

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_PEND   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_PEND = 2'd3
   } state_t;

   localparam logic                 KEY_IDLE = KEY_ACTIVE_LOW ? 1'b1 : 1'b0;
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   state_t               state;
   logic [CNT_WIDTH-1:0] count;
   logic                 sync1;
   logic                 sync2;
   logic                 key_act;

   // Both flops reset to the idle level so reset release never looks like an edge.
   always_ff @(posedge clock_50 or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= KEY_IDLE;
         sync2 <= KEY_IDLE;
      end else begin
         sync1 <= key_raw;
         sync2 <= sync1;
      end
   end

   assign key_act   = sync2 ^ KEY_IDLE;
   assign fsm_state = state;

   always_ff @(posedge clock_50 or negedge reset_n) begin
      if (!reset_n) begin
         state         <= RELEASED;
         count         <= '0;
         key_clock     <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         press_count   <= 8'd0;
      end else begin
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         unique case (state)
            RELEASED: begin
               if (key_act) begin
                  state <= PRESS_PEND;
                  count <= '0;
               end
            end
            PRESS_PEND: begin
               // A reversal drops straight back to the stable state; no partial credit kept.
               if (!key_act) begin
                  state <= RELEASED;
               end else if (count == CNT_LAST) begin
                  state       <= PRESSED;
                  key_clock   <= 1'b1;
                  press_pulse <= 1'b1;
                  press_count <= press_count + 8'd1;
               end else begin
                  count <= count + 1'b1;
               end
            end
            PRESSED: begin
               if (!key_act) begin
                  state <= RELEASE_PEND;
                  count <= '0;
               end
            end
            RELEASE_PEND: begin
               if (key_act) begin
                  state <= PRESSED;
               end else if (count == CNT_LAST) begin
                  state         <= RELEASED;
                  key_clock     <= 1'b0;
                  release_pulse <= 1'b1;
               end else begin
                  count <= count + 1'b1;
               end
            end
            default: state <= RELEASED;
         endcase
      end
   end

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with DEBOUNCE_CYCLES=4 and an active-low key.
// Edge numbering: inputs change just after an edge, so the next rising edge is edge 1.
module tb_key_debouncer;

   logic       clock_50;
   logic       reset_n;
   logic       key_raw;
   logic       key_clock;
   logic       press_pulse;
   logic       release_pulse;
   logic [7:0] press_count;
   logic [1:0] fsm_state;

   int errors = 0;
   int checks = 0;
   int press_seen = 0;
   int release_seen = 0;
   int both_high = 0;

   key_debouncer #(
      .DEBOUNCE_CYCLES(4),
      .CNT_WIDTH(3),
      .KEY_ACTIVE_LOW(1'b1)
   ) dut (
      .clock_50(clock_50),
      .reset_n(reset_n),
      .key_raw(key_raw),
      .key_clock(key_clock),
      .press_pulse(press_pulse),
      .release_pulse(release_pulse),
      .press_count(press_count),
      .fsm_state(fsm_state)
   );

   initial clock_50 = 1'b0;
   always #5 clock_50 = ~clock_50;

   always @(negedge clock_50) begin
      if (press_pulse) press_seen++;
      if (release_pulse) release_seen++;
      if (press_pulse && release_pulse) both_high++;
   end

   task automatic step();
      @(posedge clock_50);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_key_clock"}, {7'd0, key_clock}, 8'd0);
      check({tag, "_press_pulse"}, {7'd0, press_pulse}, 8'd0);
      check({tag, "_release_pulse"}, {7'd0, release_pulse}, 8'd0);
      check({tag, "_press_count"}, press_count, 8'd0);
   endtask

   logic bounce_raw [12];
   int p0;
   int r0;

   initial begin
      reset_n = 1'b0;
      key_raw = 1'b1;

      // Reset held while the key chatters.
      for (int i = 0; i < 6; i++) begin
         key_raw = i[0];
         step();
         check_idle($sformatf("rst_hold%0d", i));
      end
      key_raw = 1'b1;
      step();
      reset_n = 1'b1;
      for (int i = 0; i < 20; i++) step();
      check_idle("rst_idle");
      check("rst_no_pulses", 8'(press_seen + release_seen), 8'd0);

      // Bounce: low 3, high 1, low 2, then high.
      bounce_raw = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                     1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      for (int e = 1; e <= 12; e++) begin
         key_raw = bounce_raw[e-1];
         step();
         check($sformatf("bounce_kc_e%0d", e), {7'd0, key_clock}, 8'd0);
         check($sformatf("bounce_pp_e%0d", e), {7'd0, press_pulse}, 8'd0);
      end
      check("bounce_count", press_count, 8'd0);

      // Clean press: key_clock rises at edge 7, strobe only between edges 7 and 8.
      key_raw = 1'b0;
      for (int e = 1; e <= 9; e++) begin
         step();
         check($sformatf("press_kc_e%0d", e), {7'd0, key_clock}, (e >= 7) ? 8'd1 : 8'd0);
         check($sformatf("press_pp_e%0d", e), {7'd0, press_pulse}, (e == 7) ? 8'd1 : 8'd0);
      end
      check("press_count1", press_count, 8'd1);

      // Release with bounce: high 2, low 1, then high from edge 4 -> release at edge 10.
      for (int e = 1; e <= 12; e++) begin
         key_raw = (e == 3) ? 1'b0 : 1'b1;
         step();
         check($sformatf("rel_kc_e%0d", e), {7'd0, key_clock}, (e < 10) ? 8'd1 : 8'd0);
         check($sformatf("rel_rp_e%0d", e), {7'd0, release_pulse}, (e == 10) ? 8'd1 : 8'd0);
         check($sformatf("rel_pp_e%0d", e), {7'd0, press_pulse}, 8'd0);
      end
      check("rel_pulse_total", 8'(release_seen), 8'd1);

      // Wrap: start from a fresh reset, then 256 clean press/release cycles.
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      step();
      p0 = press_seen;
      r0 = release_seen;
      for (int n = 1; n <= 256; n++) begin
         key_raw = 1'b0;
         for (int i = 0; i < 8; i++) step();
         key_raw = 1'b1;
         for (int i = 0; i < 8; i++) step();
         if (n == 255) check("wrap_count255", press_count, 8'd255);
      end
      check("wrap_count0", press_count, 8'd0);
      check("wrap_kc", {7'd0, key_clock}, 8'd0);
      checks++;
      assert (press_seen - p0 == 256) else begin
         errors++;
         $error("FAIL wrap_press_pulses: observed=%0d expected=256", press_seen - p0);
      end
      checks++;
      assert (release_seen - r0 == 256) else begin
         errors++;
         $error("FAIL wrap_release_pulses: observed=%0d expected=256", release_seen - r0);
      end

      // Reset mid-debounce: 5 edges puts the FSM in PRESS_PEND with count 2.
      key_raw = 1'b0;
      for (int i = 0; i < 5; i++) step();
      check("mid_not_yet", {7'd0, key_clock}, 8'd0);
      #2 reset_n = 1'b0;
      #1;
      check_idle("mid_rst");
      step();
      reset_n = 1'b1;
      for (int e = 1; e <= 9; e++) begin
         step();
         check($sformatf("mid_kc_e%0d", e), {7'd0, key_clock}, (e >= 7) ? 8'd1 : 8'd0);
         check($sformatf("mid_pp_e%0d", e), {7'd0, press_pulse}, (e == 7) ? 8'd1 : 8'd0);
      end
      check("mid_count1", press_count, 8'd1);

      check("never_both_pulses", 8'(both_high), 8'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
